// File: rtl/cpu_trace_checker_pkg.sv
// cpu_trace_checker_pkg: shared encodings for the cpu trace checker
package cpu_trace_checker_pkg;
    localparam int STAGE_COUNT = 5;
    localparam logic [STAGE_COUNT-1:0] STAGE_WB = 5'b10000;
    localparam int DEF_STACK_START = 'hFF;

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_RUN   = 2'd1,
        CHK_SPCHK = 2'd2,
        CHK_FAIL  = 2'd3
    } chk_state_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_OVERFLOW  = 3'd1,
        ERR_UNDERFLOW = 3'd2,
        ERR_DATA      = 3'd3,
        ERR_SP        = 3'd4,
        ERR_HANG      = 3'd5,
        ERR_PROTO     = 3'd6
    } err_code_t;

    // lowest-numbered raised error wins when several fire together
    function automatic logic [2:0] first_err(input logic [6:1] e);
        first_err = ERR_NONE;
        for (int i = 6; i >= 1; i--)
            if (e[i]) first_err = 3'(i);
    endfunction
endpackage

// File: rtl/trace_lifo.sv
// trace_lifo: shadow stack storage; only the fill pointer is reset
module trace_lifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW:0] cnt;

    assign full  = cnt == (PW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign rdata = mem[cnt[PW-1:0] - 1'b1];

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (push && !full) cnt <= cnt + 1'b1;
        else if (pop && !empty) cnt <= cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[cnt[PW-1:0]] <= wdata;
    end
endmodule

// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker: shadow stack/SP model, retire counter and PC-hang watchdog
// beside the pipelined cpu, reporting a sticky first error code and its pc.
module cpu_trace_checker
    import cpu_trace_checker_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int I_ADDR_WIDTH = 10,
    parameter int D_ADDR_WIDTH = 16,
    parameter int STACK_DEPTH  = 16,
    parameter logic [D_ADDR_WIDTH-1:0] STACK_START = D_ADDR_WIDTH'(DEF_STACK_START),
    parameter int CNT_WIDTH    = 16,
    parameter int WDOG_CYCLES  = 64,
    parameter bit STOP_ON_ERROR = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [I_ADDR_WIDTH-1:0] pc,
    input  logic [STAGE_COUNT-1:0]  stage,
    input  logic                    push_valid,
    input  logic                    pop_valid,
    input  logic [DATA_WIDTH-1:0]   stack_data,
    input  logic [D_ADDR_WIDTH-1:0] cpu_sp,
    output logic                    result,
    output logic                    error,
    output logic [2:0]              err_code,
    output logic [I_ADDR_WIDTH-1:0] err_pc,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic [CNT_WIDTH-1:0]    retired,
    output logic [D_ADDR_WIDTH-1:0] model_sp,
    output logic [1:0]              state
);
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(WDOG_CYCLES);

    chk_state_t st, st_nx;
    logic [I_ADDR_WIDTH-1:0] prev_pc;
    logic [WW-1:0] wd, wd_nx;
    logic wb_q, run_en, live, do_push, do_pop, pc_same, checked, any_err;
    logic lifo_full, lifo_empty;
    logic [DATA_WIDTH-1:0] lifo_top;
    logic [6:1] errs;

    trace_lifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(STACK_DEPTH)) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (stack_data),
        .rdata (lifo_top),
        .full  (lifo_full),
        .empty (lifo_empty)
    );

    always_comb begin
        run_en  = enable && st == CHK_RUN;
        live    = enable && (st == CHK_RUN || st == CHK_SPCHK);
        do_push = run_en && push_valid && !pop_valid;
        do_pop  = run_en && pop_valid && !push_valid;
        pc_same = pc == prev_pc;
        // watchdog saturates at the limit so a hang reports only once until pc moves
        wd_nx   = !pc_same ? '0 : (wd == WD_LIMIT) ? wd : wd + 1'b1;
        errs    = '0;
        errs[ERR_OVERFLOW]  = do_push && lifo_full;
        errs[ERR_UNDERFLOW] = do_pop && lifo_empty;
        errs[ERR_DATA]      = do_pop && !lifo_empty && lifo_top != stack_data;
        errs[ERR_SP]        = st == CHK_SPCHK && cpu_sp != model_sp;
        errs[ERR_HANG]      = live && pc_same && wd == WD_LIMIT - 1'b1;
        errs[ERR_PROTO]     = (run_en && push_valid && pop_valid) ||
                              (enable && st == CHK_SPCHK && (push_valid || pop_valid));
        any_err = |errs;
        checked = do_push || do_pop || st == CHK_SPCHK;
        st_nx   = (any_err && STOP_ON_ERROR) ? CHK_FAIL :
                  (st == CHK_IDLE)  ? (enable ? CHK_RUN : CHK_IDLE) :
                  (st == CHK_SPCHK) ? CHK_RUN :
                  (st == CHK_RUN && (do_push || do_pop)) ? CHK_SPCHK : st;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= CHK_IDLE;
            result    <= 1'b1;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            err_pc    <= '0;
            err_count <= '0;
            retired   <= '0;
            model_sp  <= STACK_START;
            prev_pc   <= '0;
            wd        <= '0;
            wb_q      <= 1'b0;
        end else begin
            st <= st_nx;
            if (do_push) model_sp <= model_sp - 1'b1;
            else if (do_pop) model_sp <= model_sp + 1'b1;
            if (live) wd <= wd_nx;
            if (enable && st != CHK_FAIL) begin
                prev_pc <= pc;
                wb_q    <= live && stage == STAGE_WB;
                if (wb_q && !pc_same && retired != '1) retired <= retired + 1'b1;
            end
            if (any_err) begin
                result <= 1'b0;
                error  <= 1'b1;
                if (!error) begin
                    err_code <= first_err(errs);
                    err_pc   <= pc;
                end
                if (err_count != '1) err_count <= err_count + 1'b1;
            end else if (checked) begin
                result <= 1'b1;
            end
        end
    end

    assign state = st;
endmodule

// File: tb/tb_cpu_trace_checker.sv
// tb_cpu_trace_checker: directed spec scenarios plus random traffic against a queue-based reference model
module tb_cpu_trace_checker;
    localparam int DEPTH = 4;
    localparam int WD    = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, enable = 1'b0, push_valid = 1'b0, pop_valid = 1'b0;
    logic [9:0]  pc = '0;
    logic [4:0]  stage = 5'b00001;
    logic [7:0]  stack_data = '0;
    logic [15:0] cpu_sp = '0;

    logic        d_result, d_error, s_result, s_error;
    logic [2:0]  d_code, s_code;
    logic [9:0]  d_epc, s_epc;
    logic [15:0] d_cnt, d_ret, d_sp, s_cnt, s_ret, s_sp;
    logic [1:0]  d_state, s_state;

    cpu_trace_checker #(.STACK_DEPTH(DEPTH), .STOP_ON_ERROR(1'b0)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .pc(pc), .stage(stage),
        .push_valid(push_valid), .pop_valid(pop_valid), .stack_data(stack_data), .cpu_sp(cpu_sp),
        .result(d_result), .error(d_error), .err_code(d_code), .err_pc(d_epc),
        .err_count(d_cnt), .retired(d_ret), .model_sp(d_sp), .state(d_state)
    );

    cpu_trace_checker u_stop (
        .clk(clk), .reset(reset), .enable(enable), .pc(pc), .stage(stage),
        .push_valid(push_valid), .pop_valid(pop_valid), .stack_data(stack_data), .cpu_sp(cpu_sp),
        .result(s_result), .error(s_error), .err_code(s_code), .err_pc(s_epc),
        .err_count(s_cnt), .retired(s_ret), .model_sp(s_sp), .state(s_state)
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model of the STOP_ON_ERROR=0, depth-4 instance
    int          m_state, m_wd, nxt;
    logic        m_result, m_error, m_wbq, chk_f, live;
    logic [2:0]  m_code;
    logic [9:0]  m_epc, m_prev;
    logic [15:0] m_cnt, m_ret, m_sp;
    logic [6:0]  errs;
    logic [7:0]  q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_result = 1; m_error = 0; m_code = 0; m_epc = 0;
            m_cnt = 0; m_ret = 0; m_sp = 16'h00FF; q.delete(); m_wd = 0; m_prev = 0; m_wbq = 0;
        end else begin
            errs = 0; chk_f = 0; nxt = m_state;
            live = enable && (m_state == 1 || m_state == 2);
            if (m_state == 0 && enable) nxt = 1;
            if (m_state == 2) begin
                chk_f = 1; nxt = 1;
                if (cpu_sp != m_sp) errs[4] = 1;
                if (enable && (push_valid || pop_valid)) errs[6] = 1;
            end
            if (m_state == 1 && enable) begin
                if (push_valid && pop_valid) errs[6] = 1;
                else if (push_valid) begin
                    chk_f = 1; nxt = 2; m_sp = m_sp - 1;
                    if (q.size() == DEPTH) errs[1] = 1; else q.push_back(stack_data);
                end else if (pop_valid) begin
                    chk_f = 1; nxt = 2; m_sp = m_sp + 1;
                    if (q.size() == 0) errs[2] = 1;
                    else begin
                        if (q[$] != stack_data) errs[3] = 1;
                        void'(q.pop_back());
                    end
                end
            end
            if (live) begin
                if (pc == m_prev) begin
                    if (m_wd == WD - 1) errs[5] = 1;
                    if (m_wd < WD) m_wd++;
                end else m_wd = 0;
            end
            if (enable && m_state != 3) begin
                if (m_wbq && pc != m_prev && m_ret != 16'hFFFF) m_ret++;
                m_wbq = live && stage == 5'b10000;
                m_prev = pc;
            end
            if (errs != 0) begin
                for (int i = 6; i >= 1; i--) if (errs[i] && !m_error) m_code = 3'(i);
                if (!m_error) m_epc = pc;
                m_error = 1; m_result = 0;
                if (m_cnt != 16'hFFFF) m_cnt++;
            end else if (chk_f) m_result = 1;
            m_state = nxt;
        end
    end

    task automatic check_all();
        check("state", 32'(d_state), 32'(m_state));
        check("result", 32'(d_result), 32'(m_result));
        check("error", 32'(d_error), 32'(m_error));
        check("err_code", 32'(d_code), 32'(m_code));
        check("err_pc", 32'(d_epc), 32'(m_epc));
        check("err_count", 32'(d_cnt), 32'(m_cnt));
        check("retired", 32'(d_ret), 32'(m_ret));
        check("model_sp", 32'(d_sp), 32'(m_sp));
    endtask

    task automatic drive(input logic en, input logic pu, input logic po, input logic [7:0] d,
                         input logic bad_sp, input logic hold);
        enable = en; push_valid = pu; pop_valid = po; stack_data = d;
        pc = hold ? pc : pc + 10'd1;
        stage = 5'b00001 << $urandom_range(0, 4);
        cpu_sp = bad_sp ? m_sp ^ 16'h0001 : m_sp;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        check("rst_state", 32'(d_state), 0);
        check("rst_result", 32'(d_result), 1);
        check("rst_error", 32'(d_error), 0);
        check("rst_code", 32'(d_code), 0);
        check("rst_cnt", 32'(d_cnt), 0);
        check("rst_ret", 32'(d_ret), 0);
        check("rst_sp", 32'(d_sp), 32'h00FF);
        check("rst_stop_state", 32'(s_state), 0);
        reset = 1'b0;
    endtask

    logic [9:0] pop_pc;
    logic       pu, po;
    logic [7:0] d;

    initial begin
        @(negedge clk);
        do_reset();
        // balanced push/pop sequence with correct SP reports
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 8'd5, 0, 0);  drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 8'd15, 0, 0); drive(1, 0, 0, 0, 0, 0);
        check("bal_sp_mid", 32'(d_sp), 32'h00FD);
        drive(1, 0, 1, 8'd15, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 8'd5, 0, 0);  drive(1, 0, 0, 0, 0, 0);
        check("bal_cnt", 32'(d_cnt), 0);
        check("bal_sp", 32'(d_sp), 32'h00FF);
        check("bal_result", 32'(d_result), 1);
        check("bal_stop_error", 32'(s_error), 0);
        // pop data mismatch
        drive(1, 1, 0, 8'd5, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 8'd7, 0, 0); pop_pc = pc;
        check("mis_code", 32'(d_code), 3);
        check("mis_stop_code", 32'(s_code), 3);
        check("mis_stop_pc", 32'(s_epc), 32'(pop_pc));
        check("mis_stop_state", 32'(s_state), 3);
        drive(1, 0, 0, 0, 0, 0); drive(1, 1, 0, 8'd1, 0, 0);
        check("fail_hold_state", 32'(s_state), 3);
        check("fail_hold_result", 32'(s_result), 0);
        check("fail_hold_cnt", 32'(s_cnt), 1);
        // SP mismatch, run continues
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 8'd8, 0, 0); drive(1, 0, 0, 0, 1, 0);
        check("sp_code", 32'(d_code), 4);
        check("sp_cnt", 32'(d_cnt), 1);
        check("sp_state", 32'(d_state), 1);
        // underflow, then overflow on 5th push
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 8'd3, 0, 0);
        check("under_code", 32'(d_code), 2);
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 8'(i + 1), 0, 0);
            if (i < 4) drive(1, 0, 0, 0, 0, 0);
        end
        check("over_code", 32'(d_code), 1);
        check("over_cnt", 32'(d_cnt), 1);
        check("over_sp", 32'(d_sp), 32'h00FA);
        drive(1, 0, 0, 0, 0, 0);
        // simultaneous push and pop
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 8'd9, 0, 0);
        check("both_code", 32'(d_code), 6);
        check("both_sp", 32'(d_sp), 32'h00FF);
        check("both_state", 32'(d_state), 1);
        drive(1, 0, 1, 8'd9, 0, 0);
        check("both_empty_cnt", 32'(d_cnt), 2);
        drive(1, 0, 0, 0, 0, 0);
        // pc hang
        do_reset();
        drive(1, 0, 0, 0, 0, 1);
        repeat (63) drive(1, 0, 0, 0, 0, 1);
        check("hang_early", 32'(d_error), 0);
        drive(1, 0, 0, 0, 0, 1);
        check("hang_code", 32'(d_code), 5);
        repeat (20) drive(1, 0, 0, 0, 0, 1);
        check("hang_once", 32'(d_cnt), 1);
        // disabled checker never hangs
        do_reset();
        drive(1, 0, 0, 0, 0, 1);
        repeat (100) drive(0, 0, 0, 0, 0, 1);
        check("dis_error", 32'(d_error), 0);
        check("dis_state", 32'(d_state), 1);
        // reset in the middle of SPCHK
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 8'd9, 0, 0);
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 8'd9, 0, 0);
        check("rst_mid_lifo", 32'(d_code), 2);
        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int k;
            reset = ($urandom_range(0, 499) == 0);
            k = $urandom_range(0, 99);
            pu = k < 25 || (k >= 50 && k < 53);
            po = (k >= 25 && k < 53);
            if (m_state == 2 && $urandom_range(0, 99) < 85) begin pu = 0; po = 0; end
            d = (po && !pu && q.size() > 0 && $urandom_range(0, 9) != 0) ? q[$] : 8'($urandom);
            drive($urandom_range(0, 9) != 0, pu, po, d, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0);
        end
        reset = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
